// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size encodings, FSM states and default RAM geometry for mem_access_ctrl.
package mem_access_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: combinational load lane select/extension and store lane merge.
module mem_lane_unit
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  lane,
  input  logic [31:0] old,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] shifted;
  always_comb begin
    sh = size == SZ_BYTE ? {lane, 3'b0} : size == SZ_HALF ? {lane[1], 4'b0} : 5'd0;
    mask = size == SZ_BYTE ? 32'h0000_00FF : size == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    shifted = old >> sh;
    ld_data = size == SZ_BYTE ? {{24{sgn & shifted[7]}}, shifted[7:0]} :
              size == SZ_HALF ? {{16{sgn & shifted[15]}}, shifted[15:0]} : shifted;
    st_data = (old & ~(mask << sh)) | ((wdata & mask) << sh);
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer in front of a 2^ADDR_W x 32 RAM with read-modify-write for partial stores.
// Define MEM_ACCESS_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_input,
  output logic              ram_write_enable,
  output logic              ram_read_enable,
  input  logic [DATA_W-1:0] ram_data_output
);
  state_t      state;
  logic        we;
  logic        sgn;
  logic [1:0]  size;
  logic [1:0]  lane;
  logic [31:0] wdata;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic        fault;
  always_comb begin
    fault = (|req_addr[31:ADDR_W+2]) || req_size == 2'b11;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    fault = fault || (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && |req_addr[1:0]);
`endif
  end
  mem_lane_unit u_lane (
    .size    (size),
    .sgn     (sgn),
    .lane    (lane),
    .old     (ram_data_output),
    .wdata   (wdata),
    .ld_data (ld_data),
    .st_data (st_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      ram_address <= '0;
      ram_data_input <= '0;
      ram_write_enable <= 1'b0;
      ram_read_enable <= 1'b0;
      we <= 1'b0;
      sgn <= 1'b0;
      size <= SZ_BYTE;
      lane <= 2'b0;
      wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          we <= req_we;
          size <= req_size;
          sgn <= req_signed;
          lane <= req_addr[1:0];
          wdata <= req_wdata;
          ram_address <= req_addr[ADDR_W+1:2];
          if (fault) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_rdata <= '0;
          end else if (req_we && req_size == SZ_WORD) begin
            state <= WRITE;
            ram_write_enable <= 1'b1;
            ram_data_input <= req_wdata;
          end else begin
            state <= READ;
            ram_read_enable <= 1'b1;
          end
        end
        // loads finish here; partial stores merge the old word and go on to WRITE
        READ: begin
          ram_read_enable <= 1'b0;
          if (we) begin
            state <= WRITE;
            ram_write_enable <= 1'b1;
            ram_data_input <= st_data;
          end else begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b0;
            rsp_rdata <= ld_data;
          end
        end
        WRITE: begin
          ram_write_enable <= 1'b0;
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_rdata <= '0;
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench for mem_access_ctrl with a behavioural RAM.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] ram_address;
  logic [31:0] ram_data_input;
  logic        ram_write_enable;
  logic        ram_read_enable;
  logic [31:0] ram_data_output;

  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:65535];
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [15:0] last_wr = '0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_address(ram_address), .ram_data_input(ram_data_input),
    .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
    .ram_data_output(ram_data_output)
  );

  always #5 clk = ~clk;

  assign ram_data_output = mem[ram_address];
  always @(posedge clk) begin
    if (ram_write_enable) begin
      mem[ram_address] <= ram_data_input;
      wr_cnt <= wr_cnt + 1;
      last_wr <= ram_address;
    end
    if (ram_read_enable) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_read_enable && ram_write_enable) check("rd_wr_overlap", 1, 0);
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input string name);
    int lat;
    q.push_back('{exp_rdata, exp_err});
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    check({name, " req_ready"}, {31'b0, req_ready}, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " idle"}, {31'b0, req_ready}, 1);
  endtask

  task automatic run(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_rd, input int exp_wr, input string name);
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(we, size, sgn, addr, wdata, exp_rdata, exp_err, exp_lat, name);
    wait_idle(name);
    check({name, " reads"}, rd_cnt - rd0, exp_rd);
    check({name, " writes"}, wr_cnt - wr0, exp_wr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", {31'b0, req_ready}, 1);
    check("rst rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst rd_en", {31'b0, ram_read_enable}, 0);
    check("rst wr_en", {31'b0, ram_write_enable}, 0);
    check("rst ram_address", {16'b0, ram_address}, 0);
    check("rst rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(1, SZ_WORD, 0, 32'h108, 32'h1234_5678, 0, 0, 2, 0, 1, "st_word");
    check("st_word addr", {16'b0, last_wr}, 32'h42);
    check("st_word mem", mem[16'h42], 32'h1234_5678);
    run(0, SZ_WORD, 0, 32'h108, 0, 32'h1234_5678, 0, 2, 1, 0, "ld_word");

    run(1, SZ_WORD, 0, 32'h108, 32'hAABB_CCDD, 0, 0, 2, 0, 1, "preload1");
    run(1, SZ_BYTE, 0, 32'h10A, 32'h0000_007F, 0, 0, 3, 1, 1, "st_byte");
    check("st_byte addr", {16'b0, last_wr}, 32'h42);
    check("st_byte mem", mem[16'h42], 32'hAA7F_CCDD);

    run(1, SZ_WORD, 0, 32'h108, 32'hAA80_CCDD, 0, 0, 2, 0, 1, "preload2");
    run(0, SZ_BYTE, 1, 32'h10A, 0, 32'hFFFF_FF80, 0, 2, 1, 0, "ld_byte_s");
    run(0, SZ_BYTE, 0, 32'h10A, 0, 32'h0000_0080, 0, 2, 1, 0, "ld_byte_u");
    run(0, SZ_HALF, 1, 32'h10A, 0, 32'hFFFF_AA80, 0, 2, 1, 0, "ld_half_s");
    run(1, SZ_HALF, 0, 32'h108, 32'h0000_1357, 0, 0, 3, 1, 1, "st_half");
    check("st_half mem", mem[16'h42], 32'hAA80_1357);

    run(1, SZ_WORD, 0, 32'h100, 32'h1234_F00D, 0, 0, 2, 0, 1, "preload3");
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    run(0, SZ_HALF, 0, 32'h101, 0, 0, 1, 1, 0, 0, "ld_half_mis");
`else
    run(0, SZ_HALF, 0, 32'h101, 0, 32'h0000_F00D, 0, 2, 1, 0, "ld_half_mis");
`endif

    run(1, SZ_WORD, 0, 32'h4_0000, 32'hDEAD_BEEF, 0, 1, 1, 0, 0, "st_oor");
    run(1, SZ_WORD, 0, 32'h3_FFFC, 32'hCAFE_BABE, 0, 0, 2, 0, 1, "st_top");
    check("st_top addr", {16'b0, last_wr}, 32'hFFFF);
    check("st_top mem", mem[16'hFFFF], 32'hCAFE_BABE);
    run(0, SZ_WORD, 0, 32'h3_FFFC, 0, 32'hCAFE_BABE, 0, 2, 1, 0, "ld_top");
    run(0, 2'b11, 0, 32'h108, 0, 0, 1, 1, 0, 0, "bad_size");

    rsp_ready = 1'b0;
    issue(0, SZ_WORD, 0, 32'h108, 0, 32'hAA80_1357, 0, 2, "hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold rsp_valid", {31'b0, rsp_valid}, 1);
      check("hold rsp_rdata", rsp_rdata, 32'hAA80_1357);
      check("hold req_ready", {31'b0, req_ready}, 0);
    end
    rsp_ready = 1'b1;
    wait_idle("hold");

    req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 32'h200; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid wr_en", {31'b0, ram_write_enable}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid req_ready", {31'b0, req_ready}, 1);
    check("rst_mid wr_en_after", {31'b0, ram_write_enable}, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_mid rsp_valid", {31'b0, rsp_valid}, 0);
    end
    run(0, SZ_WORD, 0, 32'h108, 0, 32'hAA80_1357, 0, 2, 1, 0, "after_rst");

    @(posedge clk); #1;
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage controller sitting directly upstream of the 2^16 x 32 RAM (RAM_2_16x32).
- Accepts byte-addressed load/store requests from the CPU pipeline over a valid/ready handshake.
- Sequences the RAM's write_enable/read_enable/address/data_input and does read-modify-write for byte/halfword stores.
- Returns sign- or zero-extended load data over a valid/ready response channel.

Parameters:
- ADDR_W, 16, RAM word-address width; byte address width is ADDR_W+2.
- DATA_W, 32, RAM word width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_signed  in  1  sign-extend loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; right-aligned for byte/half.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  request faulted; no RAM write occurred.
- ram_address  out  ADDR_W  word address to RAM.
- ram_data_input  out  32  write data to RAM.
- ram_write_enable  out  1  RAM write strobe.
- ram_read_enable  out  1  RAM read strobe.
- ram_data_output  in  32  RAM read data, valid while read_enable is high.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. All outputs 0 except req_ready=1. Abandons any operation in flight. No further RAM strobes are issued and no response is produced.
- States: IDLE, READ, WRITE, RESP.
- Request acceptance:
  - req_ready=1 only in IDLE.
  - A request is accepted when req_valid && req_ready at a posedge.
  - On acceptance, the controller latches we, size, signed, addr and wdata.
- Word address: waddr = addr[ADDR_W+1:2].
- Fault conditions, any of:
  - addr[31:ADDR_W+2] != 0 (out of range).
  - req_size == 11.
  - Misalignment: half with addr[0]=1, or word with addr[1:0] != 0.
- Fault path: IDLE -> RESP with rsp_err=1 and rsp_rdata=0. No RAM strobe is asserted.
- Load: IDLE -> READ -> RESP.
  - In READ: ram_read_enable=1 and ram_address=waddr for exactly one cycle; ram_data_output is captured at the end of that cycle.
  - Lane selection: byte lane = addr[1:0], lane 0 = bits[7:0]; half lane = addr[1], half 0 = bits[15:0].
  - Extension: zero-extend if signed=0, otherwise replicate the MSB of the selected lane.
- Word store: IDLE -> WRITE -> RESP.
  - In WRITE: ram_write_enable=1, ram_address=waddr and ram_data_input=wdata for exactly one cycle.
- Partial store: IDLE -> READ -> WRITE -> RESP.
  - READ captures the old word.
  - WRITE drives the old word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
- RAM bus hygiene:
  - ram_read_enable and ram_write_enable are never high in the same cycle.
  - Both are 0 in IDLE and RESP.
  - ram_address and ram_data_input are registered and held stable for the whole strobe cycle.
- Response:
  - In RESP: rsp_valid=1, with rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready.
  - After the handshake: next state IDLE, rsp_valid drops the following cycle.
- Latency with rsp_ready tied 1: rsp_valid rises 2 cycles after acceptance for a load or word store, 3 for a partial store, 1 for a fault.
- Throughput: one request in flight; no overlap.
- Address 0 and the top word 0xFFFF (byte 0x3FFFC) are both legal; there is no wrap-around. Byte address 0x40000 faults.

Optional Feature:
- Macro: MEM_ACCESS_ALIGN_CHECK_EN.
- Defined: misaligned half/word requests fault as described above.
- Undefined: misalignment is never a fault.
  - Half accesses use addr[1] only; addr[0] is ignored.
  - Word accesses ignore addr[1:0].
  - Out-of-range and size==11 checks remain.

Decomposition:
- Package mem_access_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum (IDLE/READ/WRITE/RESP).
  - ADDR_W default.
- One sub-module: mem_lane_unit. It is purely combinational: load lane select/extension and store lane merge.
- The FSM stays in mem_access_ctrl.

Test Plan:
- Store word 0x12345678 to byte 0x108, then load word from 0x108 -> exactly one write strobe at word 0x42; load returns 0x12345678, err=0, rsp_valid 2 cycles after acceptance.
- Preload word 0x42=0xAABBCCDD; store byte 0x7F to 0x10A -> one read then one write strobe at 0x42; RAM word becomes 0xAA7FCCDD; latency 3.
- With word 0x42=0xAA80CCDD: load byte 0x10A signed -> 0xFFFFFF80; unsigned -> 0x00000080; load half 0x10A signed -> 0xFFFFAA80.
- Load half from 0x101 with macro defined -> rsp_err=1 after 1 cycle, no RAM strobe. Same request with macro undefined -> returns the half at lane 0 of word 0x40.
- Store word to 0x40000 -> rsp_err=1, no write strobe. Store to 0x3FFFC -> success at word 0xFFFF.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stay stable and req_ready=0. Separately, assert rst during WRITE -> no response appears and the next request completes normally.
